// File: rtl/comma_word_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : comma_word_aligner
//  Description : Receive-side word aligner for a 10-bit PMA RX path. Searches
//                a 20-bit sliding window for the K28.5 comma (either running
//                disparity), locks onto a symbol boundary after LOCK_COUNT
//                consecutive same-offset commas, and emits aligned symbols
//                with a comma flag. LOSS_COUNT consecutive wrong-offset commas
//                while locked force a return to hunting.
//  Ports       : CLK            - word clock (recovered bit clock / 10)
//                Rst_n          - asynchronous active-low reset
//                Data_in        - unaligned symbol, bit0 = earliest bit
//                Data_valid     - Data_in valid this cycle
//                Data_out       - aligned symbol, same bit ordering
//                Data_out_valid - Data_out valid and aligner locked
//                K285           - Data_out is a K28.5 (either disparity)
//                Aligned        - lock status
//                Align_offset   - current boundary offset, 0..9
//  Revision    : 1.0 - initial release
// ============================================================================
module comma_word_aligner #(
  parameter int                    DATA_WIDTH = 10,
  parameter logic [DATA_WIDTH-1:0] COMMA_NEG  = 10'b0101111100,
  parameter logic [DATA_WIDTH-1:0] COMMA_POS  = 10'b1010000011,
  parameter int                    LOCK_COUNT = 3,
  parameter int                    LOSS_COUNT = 4
) (
  input  logic                  CLK,
  input  logic                  Rst_n,
  input  logic [DATA_WIDTH-1:0] Data_in,
  input  logic                  Data_valid,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  Data_out_valid,
  output logic                  K285,
  output logic                  Aligned,
  output logic [3:0]            Align_offset
);

  localparam logic [3:0] C_LOCK = 4'(LOCK_COUNT);
  localparam logic [3:0] C_LOSS = 4'(LOSS_COUNT);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   prev_word_q, prev_word_d;
  logic [3:0]              offset_q, offset_d;
  logic [3:0]              lock_cnt_q, lock_cnt_d;
  logic [3:0]              loss_cnt_q, loss_cnt_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic                    data_out_valid_q, data_out_valid_d;
  logic                    k285_q, k285_d;
  logic                    aligned_q, aligned_d;

  logic [2*DATA_WIDTH-1:0] w_win;
  logic [2*DATA_WIDTH-1:0] w_shift;
  logic [DATA_WIDTH-1:0]   w_match;
  logic [15:0]             w_match_pad;
  logic                    w_hit;
  logic [3:0]              w_hit_off;
  logic [3:0]              w_lock_inc;
  logic [3:0]              w_loss_inc;

  // Newest word in the upper half; offsets 0..9 start inside prev_word, so a
  // comma fully inside Data_in is only seen next word, at offset 0.
  assign w_win = {Data_in, prev_word_q};

  for (genvar o = 0; o < DATA_WIDTH; o++) begin : g_match
    assign w_match[o] = (w_win[o +: DATA_WIDTH] == COMMA_NEG) ||
                        (w_win[o +: DATA_WIDTH] == COMMA_POS);
  end

  assign w_hit       = |w_match;
  assign w_match_pad = 16'(w_match);
  assign w_shift     = w_win >> offset_q;

  // Lowest matching offset wins: scan downward so the last write is lowest.
  always_comb begin
    w_hit_off = 4'd0;
    for (int o = DATA_WIDTH - 1; o >= 0; o--) begin
      if (w_match[o]) w_hit_off = 4'(o);
    end
  end

  // Saturating increments.
  assign w_lock_inc = (lock_cnt_q == 4'hF) ? 4'hF : lock_cnt_q + 4'd1;
  assign w_loss_inc = (loss_cnt_q == 4'hF) ? 4'hF : loss_cnt_q + 4'd1;

  always_comb begin
    state_d          = state_q;
    prev_word_d      = prev_word_q;
    offset_d         = offset_q;
    lock_cnt_d       = lock_cnt_q;
    loss_cnt_d       = loss_cnt_q;
    data_out_d       = data_out_q;
    k285_d           = k285_q;
    data_out_valid_d = 1'b0;

    if (Data_valid) begin
      prev_word_d = Data_in;
      // Output uses the offset in force before this word's FSM update.
      data_out_d  = w_shift[DATA_WIDTH-1:0];
      k285_d      = w_match_pad[offset_q];

      case (state_q)
        ST_HUNT: begin
          if (w_hit) begin
            offset_d   = w_hit_off;
            lock_cnt_d = 4'd1;
            if (C_LOCK <= 4'd1) begin
              state_d    = ST_LOCKED;
              loss_cnt_d = 4'd0;
            end else begin
              state_d = ST_VERIFY;
            end
          end
        end
        ST_VERIFY: begin
          if (w_hit) begin
            if (w_hit_off == offset_q) begin
              lock_cnt_d = w_lock_inc;
              if (w_lock_inc >= C_LOCK) begin
                state_d    = ST_LOCKED;
                loss_cnt_d = 4'd0;
              end
            end else begin
              // Candidate boundary moved: restart confirmation there.
              offset_d   = w_hit_off;
              lock_cnt_d = 4'd1;
            end
          end
        end
        ST_LOCKED: begin
          if (w_hit) begin
            if (w_hit_off == offset_q) begin
              loss_cnt_d = 4'd0;
            end else begin
              loss_cnt_d = w_loss_inc;
              // Offset is kept until the next hunt hit replaces it.
              if (w_loss_inc >= C_LOSS) begin
                state_d    = ST_HUNT;
                lock_cnt_d = 4'd0;
              end
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase

      data_out_valid_d = (state_d == ST_LOCKED);
    end

    aligned_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q          <= ST_HUNT;
      prev_word_q      <= '0;
      offset_q         <= 4'd0;
      lock_cnt_q       <= 4'd0;
      loss_cnt_q       <= 4'd0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
      k285_q           <= 1'b0;
      aligned_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      prev_word_q      <= prev_word_d;
      offset_q         <= offset_d;
      lock_cnt_q       <= lock_cnt_d;
      loss_cnt_q       <= loss_cnt_d;
      data_out_q       <= data_out_d;
      data_out_valid_q <= data_out_valid_d;
      k285_q           <= k285_d;
      aligned_q        <= aligned_d;
    end
  end

  assign Data_out       = data_out_q;
  assign Data_out_valid = data_out_valid_q;
  assign K285           = k285_q;
  assign Aligned        = aligned_q;
  assign Align_offset   = offset_q;

endmodule
`default_nettype wire

// File: tb/tb_comma_word_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_comma_word_aligner
//  Description : Self-checking bench for comma_word_aligner. Table-driven
//                streams (offset 0, offset 7 mixed disparity, valid bubbles)
//                plus directed sequences for verify restart, loss of lock
//                and asynchronous mid-run reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_comma_word_aligner;

  localparam logic [9:0] KN   = 10'b0101111100;
  localparam logic [9:0] KP   = 10'b1010000011;
  localparam logic [9:0] D215 = 10'b0101010101;

  logic       CLK = 1'b0;
  logic       Rst_n = 1'b0;
  logic [9:0] Data_in = '0;
  logic       Data_valid = 1'b0;
  logic [9:0] Data_out;
  logic       Data_out_valid;
  logic       K285;
  logic       Aligned;
  logic [3:0] Align_offset;

  always #5 CLK = ~CLK;

  comma_word_aligner dut (
    .CLK            (CLK),
    .Rst_n          (Rst_n),
    .Data_in        (Data_in),
    .Data_valid     (Data_valid),
    .Data_out       (Data_out),
    .Data_out_valid (Data_out_valid),
    .K285           (K285),
    .Aligned        (Aligned),
    .Align_offset   (Align_offset)
  );

  typedef struct {
    logic       do_rst;
    logic [9:0] din;
    logic       vld;
    logic       e_vld;
    logic       e_al;
    logic [3:0] e_off;
    logic [9:0] e_out;
    logic       e_k;
  } vec_t;

  vec_t tbl[$];
  logic sbits [0:1023];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [9:0] din, input logic vld);
    @(negedge CLK);
    Data_in    = din;
    Data_valid = vld;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    Rst_n      = 1'b0;
    Data_valid = 1'b0;
    repeat (2) @(negedge CLK);
    Rst_n = 1'b1;
  endtask

  // Background: alternating bits, which read as D21.5 on even offsets and
  // can never contain a five-bit run, so only planted commas match.
  task automatic bg_fill();
    for (int i = 0; i < 1024; i++) sbits[i] = (i % 2 == 0);
  endtask

  task automatic put(input int p, input logic [9:0] v);
    for (int j = 0; j < 10; j++) sbits[p + j] = v[j];
  endtask

  function automatic logic [9:0] word_at(input int n);
    logic [9:0] w;
    for (int j = 0; j < 10; j++) w[j] = sbits[10 * n + j];
    return w;
  endfunction

  task automatic send_range(input int n0, input int n1);
    for (int n = n0; n <= n1; n++) drive(word_at(n), 1'b1);
  endtask

  function automatic vec_t mk(input logic rst, input logic [9:0] din, input logic vld,
                              input logic evld, input logic eal, input logic [3:0] eoff,
                              input logic [9:0] eout, input logic ek);
    vec_t r;
    r.do_rst = rst;  r.din = din;   r.vld = vld;
    r.e_vld  = evld; r.e_al = eal;  r.e_off = eoff;
    r.e_out  = eout; r.e_k = ek;
    return r;
  endfunction

  // Symbols k: comma when k%4==3, otherwise D21.5; symbol k starts at stream
  // bit f+10k. Comma k is seen in the window of word k+1, so the commas at
  // k=3,7,11 are detected at words 4,8,12: offset set at word 4, lock
  // confirmed at word 12, and after word n the output is symbol n-1.
  task automatic build_scn(input int f, input bit alt, input bit bub);
    logic [9:0] sym [0:20];
    logic       is_k;
    bg_fill();
    for (int k = 0; k <= 20; k++) begin
      if (k % 4 == 3) sym[k] = (alt && ((k / 4) % 2 == 1)) ? KP : KN;
      else            sym[k] = D215;
      put(f + 10 * k, sym[k]);
    end
    for (int n = 0; n < 20; n++) begin
      if (bub && (n == 6 || n == 13)) begin
        tbl.push_back(mk(1'b0, 10'h3FF, 1'b0, 1'b0, (n - 1) >= 12,
                         ((n - 1) >= 4) ? 4'(f) : 4'd0, 10'h000, 1'b0));
      end
      is_k = (n > 0) && ((n - 1) % 4 == 3);
      tbl.push_back(mk(n == 0, word_at(n), 1'b1, n >= 12, n >= 12,
                       (n >= 4) ? 4'(f) : 4'd0, (n > 0) ? sym[n - 1] : 10'h000, is_k));
    end
  endtask

  initial begin
    // Reset held with live traffic: everything stays cleared.
    Rst_n      = 1'b0;
    Data_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(10'($urandom), 1'b1);
      chk("rst data_out", Data_out, 10'h000);
      chk("rst valid", Data_out_valid, 1'b0);
      chk("rst k285", K285, 1'b0);
      chk("rst aligned", Aligned, 1'b0);
      chk("rst offset", Align_offset, 4'd0);
    end

    build_scn(0, 1'b0, 1'b0);
    build_scn(7, 1'b1, 1'b0);
    build_scn(0, 1'b0, 1'b1);

    foreach (tbl[i]) begin
      if (tbl[i].do_rst) do_reset();
      drive(tbl[i].din, tbl[i].vld);
      chk($sformatf("row%0d valid", i), Data_out_valid, tbl[i].e_vld);
      chk($sformatf("row%0d aligned", i), Aligned, tbl[i].e_al);
      chk($sformatf("row%0d offset", i), Align_offset, tbl[i].e_off);
      if (tbl[i].e_vld) begin
        chk($sformatf("row%0d data_out", i), Data_out, tbl[i].e_out);
        chk($sformatf("row%0d k285", i), K285, tbl[i].e_k);
      end
    end

    // Verify restart: commas at offset 3 (words 2,5), then offset 5
    // (words 8,11,14). Lock only on the third offset-5 comma.
    do_reset();
    bg_fill();
    put(13, KN); put(43, KP); put(75, KN); put(105, KN); put(135, KP);
    send_range(0, 5);
    chk("vr off3", Align_offset, 4'd3);
    chk("vr not aligned 2", Aligned, 1'b0);
    send_range(6, 8);
    chk("vr off5", Align_offset, 4'd5);
    chk("vr not aligned 3", Aligned, 1'b0);
    send_range(9, 11);
    chk("vr not aligned 4", Aligned, 1'b0);
    send_range(12, 14);
    chk("vr aligned 5", Aligned, 1'b1);
    chk("vr valid", Data_out_valid, 1'b1);
    chk("vr k285", K285, 1'b1);
    chk("vr data_out", Data_out, KP);

    // Loss of lock: lock at offset 2 (words 2,5,8); offset-6 commas at
    // words 11,14,17; offset-2 comma at 20 clears the loss count; offset-6
    // commas at 23,26,29,32 drop lock after 32; relock at 35,38,41.
    do_reset();
    bg_fill();
    put(12, KN); put(42, KP); put(72, KN);
    put(106, KP); put(136, KN); put(166, KP);
    put(192, KN);
    put(226, KP); put(256, KN); put(286, KP); put(316, KN);
    put(346, KP); put(376, KN); put(406, KP);
    send_range(0, 8);
    chk("ll locked", Aligned, 1'b1);
    chk("ll off2", Align_offset, 4'd2);
    send_range(9, 11);
    chk("ll wrong valid", Data_out_valid, 1'b1);
    chk("ll wrong k285", K285, 1'b0);
    send_range(12, 19);
    chk("ll hold after 3", Aligned, 1'b1);
    send_range(20, 20);
    chk("ll good comma", Aligned, 1'b1);
    chk("ll good k285", K285, 1'b1);
    chk("ll good data", Data_out, KN);
    send_range(21, 29);
    chk("ll kept", Aligned, 1'b1);
    chk("ll kept off", Align_offset, 4'd2);
    send_range(30, 32);
    chk("ll dropped", Aligned, 1'b0);
    chk("ll dropped valid", Data_out_valid, 1'b0);
    chk("ll held off", Align_offset, 4'd2);
    send_range(33, 35);
    chk("ll hunt hit off", Align_offset, 4'd6);
    chk("ll hunt hit al", Aligned, 1'b0);
    send_range(36, 40);
    chk("ll relock pending", Aligned, 1'b0);
    send_range(41, 41);
    chk("ll relocked", Aligned, 1'b1);
    chk("ll relock valid", Data_out_valid, 1'b1);
    chk("ll relock k285", K285, 1'b1);
    chk("ll relock data", Data_out, KP);

    // Asynchronous reset while locked, between clock edges.
    @(negedge CLK);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("async aligned", Aligned, 1'b0);
    chk("async valid", Data_out_valid, 1'b0);
    chk("async offset", Align_offset, 4'd0);
    chk("async data", Data_out, 10'h000);
    repeat (2) @(negedge CLK);
    Rst_n = 1'b1;
    drive(D215, 1'b1);
    chk("post rst aligned", Aligned, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
